rand_pkt_gen: RTL and testbench

- Downstream consumer of the random data generator in the simulation data-gen path.
- Takes its free-running random word each cycle and frames it into packets for one cache input port: one header word, then N payload words.
- Output uses a valid/ready handshake with sop/eop markers.
- Controls: enable, packet count limit, inter-packet gap, done flag.

---
 rtl/rand_pkt_gen_pkg.sv | 43 ++++
 rtl/rand_pkt_gen.sv | 191 +++++++++++++++++++
 tb/tb_rand_pkt_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_pkt_gen_pkg.sv
// Shared types, header layout and header builder for the random packet generator.
// The header layout is fixed by the default configuration below.
package rand_pkt_gen_pkg;

  localparam int P_DW        = 32;
  localparam int P_PORT_NUM  = 16;
  localparam int P_PW        = $clog2(P_PORT_NUM);
  localparam int P_LEN_W     = 6;
  localparam int P_MIN_WORDS = 2;
  localparam int P_GAP_W     = 8;
  localparam int P_CNT_W     = 16;
  localparam int SEQ_W       = 16;
  localparam int PRIO_W      = 3;

  localparam int DA_LSB   = 0;
  localparam int PRIO_LSB = P_PW;
  localparam int LEN_LSB  = P_PW + PRIO_W;
  localparam int SEQ_LSB  = P_DW - SEQ_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PLD,
    S_GAP,
    S_DONE
  } state_e;

  // Payload length is clamped up to MIN_WORDS so a packet never has too few words.
  function automatic logic [P_DW-1:0] build_hdr(input logic [P_DW-1:0]  rnd,
                                                input logic [SEQ_W-1:0] seq);
    logic [P_LEN_W-1:0] len;
    logic [P_DW-1:0]    hdr;
    len = rnd[LEN_LSB +: P_LEN_W];
    if (len < P_LEN_W'(P_MIN_WORDS)) len = P_LEN_W'(P_MIN_WORDS);
    hdr                      = '0;
    hdr[DA_LSB +: P_PW]      = rnd[DA_LSB +: P_PW];
    hdr[PRIO_LSB +: PRIO_W]  = rnd[PRIO_LSB +: PRIO_W];
    hdr[LEN_LSB +: P_LEN_W]  = len;
    hdr[SEQ_LSB +: SEQ_W]    = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/rand_pkt_gen.sv
// Frames a free-running random word stream into header + payload packets on a
// valid/ready interface, with run control (packet limit, inter-packet gap, done).
module rand_pkt_gen
  import rand_pkt_gen_pkg::*;
#(
  parameter int DW        = P_DW,
  parameter int PORT_NUM  = P_PORT_NUM,
  parameter int LEN_W     = P_LEN_W,
  parameter int MIN_WORDS = P_MIN_WORDS,
  parameter int GAP_W     = P_GAP_W,
  parameter int CNT_W     = P_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_pkt_num,
  input  logic [GAP_W-1:0] i_gap,
  input  logic [DW-1:0]    i_rand_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [DW-1:0]    o_data,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pkt_cnt
);

  localparam int PW = $clog2(PORT_NUM);

  // The header builder lives in the package, so the layout must match its configuration.
  if (DW != P_DW || PW != P_PW || LEN_W != P_LEN_W || MIN_WORDS != P_MIN_WORDS ||
      DW < SEQ_W + PW + PRIO_W + LEN_W) begin : g_bad_cfg
    $error("rand_pkt_gen: parameters do not match rand_pkt_gen_pkg header layout");
  end

  state_e             r_state,    w_state;
  logic               r_valid,    w_valid;
  logic [DW-1:0]      r_data,     w_data;
  logic               r_sop,      w_sop;
  logic               r_eop,      w_eop;
  logic               r_done,     w_done;
  logic [CNT_W-1:0]   r_pkt_cnt,  w_pkt_cnt;
  logic [SEQ_W-1:0]   r_seq,      w_seq;
  logic [LEN_W-1:0]   r_len,      w_len;
  logic [LEN_W-1:0]   r_word_cnt, w_word_cnt;
  logic [GAP_W-1:0]   r_gap_cnt,  w_gap_cnt;
  logic [CNT_W-1:0]   r_pkt_num,  w_pkt_num;
  logic [GAP_W-1:0]   r_gap,      w_gap;

  logic               w_xfer;
  logic               w_start_hdr;
  logic [DW-1:0]      w_hdr;
  logic [LEN_W-1:0]   w_word_cnt_inc;
  logic [CNT_W-1:0]   w_pkt_cnt_inc;

  assign w_xfer         = r_valid && i_ready;
  assign w_hdr          = build_hdr(i_rand_data, r_seq);
  assign w_word_cnt_inc = r_word_cnt + LEN_W'(1);
  assign w_pkt_cnt_inc  = r_pkt_cnt + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    w_state     = r_state;
    w_valid     = r_valid;
    w_data      = r_data;
    w_sop       = r_sop;
    w_eop       = r_eop;
    w_done      = r_done;
    w_pkt_cnt   = r_pkt_cnt;
    w_seq       = r_seq;
    w_len       = r_len;
    w_word_cnt  = r_word_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_pkt_num   = r_pkt_num;
    w_gap       = r_gap;
    w_start_hdr = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_valid = 1'b0;
        if (i_en) begin
          w_pkt_num   = i_pkt_num;
          w_gap       = i_gap;
          w_pkt_cnt   = '0;
          w_start_hdr = 1'b1;
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_data     = i_rand_data;
          w_sop      = 1'b0;
          w_word_cnt = LEN_W'(1);
          w_eop      = (r_len == LEN_W'(1));
          w_state    = S_PLD;
        end
      end
      S_PLD: begin
        if (w_xfer && !r_eop) begin
          w_data     = i_rand_data;
          w_word_cnt = w_word_cnt_inc;
          w_eop      = (w_word_cnt_inc == r_len);
        end else if (w_xfer) begin
          w_eop     = 1'b0;
          w_pkt_cnt = w_pkt_cnt_inc;
          if (r_pkt_num != '0 && w_pkt_cnt_inc == r_pkt_num) begin
            w_state = S_DONE;
            w_valid = 1'b0;
            w_done  = 1'b1;
          end else if (!i_en) begin
            w_state = S_IDLE;
            w_valid = 1'b0;
          end else if (r_gap == '0) begin
            w_start_hdr = 1'b1;
          end else begin
            w_state   = S_GAP;
            w_gap_cnt = r_gap;
            w_valid   = 1'b0;
          end
        end
      end
      S_GAP: begin
        w_gap_cnt = r_gap_cnt - GAP_W'(1);
        if (r_gap_cnt == GAP_W'(1)) begin
          if (i_en) w_start_hdr = 1'b1;
          else      w_state     = S_IDLE;
        end
      end
      S_DONE: begin
        w_valid = 1'b0;
        w_done  = 1'b1;
        if (!i_en) begin
          w_state = S_IDLE;
          w_done  = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Header issue is shared by run start, back-to-back and end-of-gap paths.
    if (w_start_hdr) begin
      w_data  = w_hdr;
      w_len   = w_hdr[LEN_LSB +: LEN_W];
      w_seq   = r_seq + SEQ_W'(1);
      w_valid = 1'b1;
      w_sop   = 1'b1;
      w_eop   = 1'b0;
      w_state = S_HDR;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_done     <= 1'b0;
      r_pkt_cnt  <= '0;
      r_seq      <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_gap_cnt  <= '0;
      r_pkt_num  <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_state;
      r_valid    <= w_valid;
      r_data     <= w_data;
      r_sop      <= w_sop;
      r_eop      <= w_eop;
      r_done     <= w_done;
      r_pkt_cnt  <= w_pkt_cnt;
      r_seq      <= w_seq;
      r_len      <= w_len;
      r_word_cnt <= w_word_cnt;
      r_gap_cnt  <= w_gap_cnt;
      r_pkt_num  <= w_pkt_num;
      r_gap      <= w_gap;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_sop     = r_sop;
  assign o_eop     = r_eop;
  assign o_done    = r_done;
  assign o_pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_rand_pkt_gen.sv
// Scoreboard bench for rand_pkt_gen: the stimulus queues expected words, a
// negedge monitor pops and compares on every transfer and checks stalls and gaps.
module tb_rand_pkt_gen;

  localparam int DW    = 32;
  localparam int GAP_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_en;
  logic [CNT_W-1:0] i_pkt_num;
  logic [GAP_W-1:0] i_gap;
  logic [DW-1:0]    i_rand_data;
  logic             i_ready;
  logic             o_valid;
  logic [DW-1:0]    o_data;
  logic             o_sop;
  logic             o_eop;
  logic             o_done;
  logic [CNT_W-1:0] o_pkt_cnt;

  rand_pkt_gen dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .i_pkt_num   (i_pkt_num),
    .i_gap       (i_gap),
    .i_rand_data (i_rand_data),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_done      (o_done),
    .o_pkt_cnt   (o_pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } word_t;

  word_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] low_fields;
  int          cur_prio, cur_da;
  logic [15:0] exp_seq;
  int          exp_gap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Random word = {cycle number, header fields chosen by the test}.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    i_rand_data = {cyc[15:0], low_fields};
  endtask

  task automatic set_fields(input int len_raw, input int prio, input int da);
    low_fields  = {3'b000, 6'(len_raw), 3'(prio), 4'(da)};
    cur_prio    = prio;
    cur_da      = da;
    i_rand_data = {cyc[15:0], low_fields};
  endtask

  task automatic push_hdr(input int lenc);
    word_t w;
    w.data = {exp_seq, 3'b000, 6'(lenc), 3'(cur_prio), 4'(cur_da)};
    w.sop  = 1'b1;
    w.eop  = 1'b0;
    sb_q.push_back(w);
    exp_seq++;
  endtask

  task automatic push_pld(input int t, input logic last);
    word_t w;
    w.data = {16'(t), low_fields};
    w.sop  = 1'b0;
    w.eop  = last;
    sb_q.push_back(w);
  endtask

  // Ready held high: payload k is the random word of the k-th interval after the build.
  task automatic push_pkt(input int h, input int lenc);
    push_hdr(lenc);
    for (int k = 1; k <= lenc; k++) push_pld(h + k, k == lenc);
  endtask

  task automatic start_run(input int pkt_num, input int gap, output int h);
    i_pkt_num = CNT_W'(pkt_num);
    i_gap     = GAP_W'(gap);
    i_en      = 1'b1;
    h         = cyc;
  endtask

  task automatic wait_done(input string name, input int limit);
    for (int i = 0; i < limit && !o_done; i++) tick();
    check(name, o_done, 1);
  endtask

  task automatic end_run(input string name);
    i_en = 1'b0;
    tick();
    tick();
    check(name, o_done, 0);
  endtask

  // Monitor
  logic        counting = 1'b0;
  int          idle = 0;
  logic        stalled = 1'b0;
  logic [34:0] held;
  word_t       mon_w;

  always @(negedge clk) begin
    if (rst) begin
      counting = 1'b0;
      stalled  = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {o_valid, o_data, o_sop, o_eop}, held);
      if (o_valid && o_sop && counting) begin
        check("gap_len", idle, exp_gap);
        counting = 1'b0;
      end
      if (!o_valid && counting) idle++;
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {o_data, o_sop, o_eop});
        end else begin
          mon_w = sb_q.pop_front();
          check("word", {o_data, o_sop, o_eop}, mon_w);
        end
        if (o_eop) begin
          counting = 1'b1;
          idle     = 0;
        end
      end
      if (o_done || !i_en) counting = 1'b0;
      stalled = o_valid && !i_ready;
      held    = {o_valid, o_data, o_sop, o_eop};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h;
    rst         = 1'b1;
    i_en        = 1'b0;
    i_ready     = 1'b1;
    i_pkt_num   = '0;
    i_gap       = '0;
    low_fields  = '0;
    cur_prio    = 0;
    cur_da      = 0;
    i_rand_data = '0;
    exp_seq     = '0;
    exp_gap     = 0;
    repeat (3) tick();
    check("rst_ctrl", {o_valid, o_sop, o_eop, o_done}, 4'b0000);
    check("rst_data", o_data, 0);
    check("rst_cnt", o_pkt_cnt, 0);
    rst = 1'b0;
    tick();

    // Single packet, raw len 3
    set_fields(3, 5, 9);
    start_run(1, 0, h);
    push_pkt(h, 3);
    wait_done("t1_done", 20);
    check("t1_cnt", o_pkt_cnt, 1);
    end_run("t1_done_clr");
    check("t1_cnt_hold", o_pkt_cnt, 1);

    // Length clamp: raw 0 and raw 1 both become 2
    set_fields(0, 1, 3);
    start_run(1, 0, h);
    push_pkt(h, 2);
    wait_done("t2a_done", 20);
    end_run("t2a_done_clr");
    set_fields(1, 7, 15);
    start_run(1, 0, h);
    push_pkt(h, 2);
    wait_done("t2b_done", 20);
    check("t2b_cnt", o_pkt_cnt, 1);
    end_run("t2b_done_clr");

    // Backpressure: ready 1,0,0,1 across the payload
    set_fields(4, 2, 6);
    start_run(1, 0, h);
    push_hdr(4);
    push_pld(h + 1, 1'b0);
    push_pld(h + 2, 1'b0);
    push_pld(h + 5, 1'b0);
    push_pld(h + 6, 1'b1);
    tick();
    tick();
    tick();
    i_ready = 1'b0;
    tick();
    tick();
    i_ready = 1'b1;
    wait_done("t3_done", 20);
    end_run("t3_done_clr");

    // Three packets with gap 2, then back-to-back
    set_fields(2, 3, 12);
    exp_gap = 2;
    start_run(3, 2, h);
    push_pkt(h, 2);
    push_pkt(h + 5, 2);
    push_pkt(h + 10, 2);
    wait_done("t4a_done", 40);
    check("t4a_cnt", o_pkt_cnt, 3);
    end_run("t4a_done_clr");
    exp_gap = 0;
    start_run(3, 0, h);
    push_pkt(h, 2);
    push_pkt(h + 3, 2);
    push_pkt(h + 6, 2);
    wait_done("t4b_done", 40);
    check("t4b_cnt", o_pkt_cnt, 3);
    end_run("t4b_done_clr");

    // Enable drops during payload word 2 of 5, unlimited run
    set_fields(5, 4, 1);
    start_run(0, 3, h);
    push_pkt(h, 5);
    tick();
    tick();
    tick();
    i_en = 1'b0;
    repeat (10) tick();
    check("t5_valid", o_valid, 0);
    check("t5_done", o_done, 0);
    check("t5_cnt", o_pkt_cnt, 1);

    // Reset during payload word 1, then a fresh run restarts seq at 0
    set_fields(3, 0, 2);
    start_run(0, 0, h);
    push_hdr(3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t6_ctrl", {o_valid, o_sop, o_eop, o_done}, 4'b0000);
    check("t6_data", o_data, 0);
    check("t6_cnt", o_pkt_cnt, 0);
    rst       = 1'b0;
    i_pkt_num = CNT_W'(1);
    exp_seq   = '0;
    push_pkt(cyc, 3);
    tick();
    check("t6_sop", {o_valid, o_sop}, 2'b11);
    check("t6_seq", o_data[31:16], 0);
    wait_done("t6_done", 20);
    end_run("t6_done_clr");

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
